serial_transmitter: RTL
=======================

Name: serial_transmitter

Overview:
- Parallel-in, serial-out asynchronous line transmitter: the driving end of the team's serial link.
- Accepts one byte from a producer over a dav_/rfd four-phase handshake.
- Emits the byte on txd as an idle-high frame: start bit, data bits LSB first, stop bit.
- Sits between a processor-side interface register and the external serial line; pairs with the serial receiver.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8)
CLKS_PER_BIT, 16, clock cycles per bit cell (>=2)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset_  input  1  synchronous reset, active-low; sampled on rising clock edge
dav_  input  1  data available, active-low, driven by producer
byte_in  input  DATA_BITS  data to send; must be valid while dav_=0
rfd  output  1  ready for data, active-high
txd  output  1  serial line, idle high
busy  output  1  high from capture cycle until the stop bit completes

Behaviour:
- Reset (reset_=0 at a rising edge): txd=1, rfd=1, busy=0, state=IDLE, bit and cycle counters=0, shift register=0.
- Reset takes priority over everything. A reset mid-frame aborts the frame: txd returns to 1 on that edge, and no partial bits are resumed.
- States: IDLE, START, DATA, STOP, WAIT_DAV.

IDLE (rfd=1):
- On an edge with dav_=0: capture byte_in into the shift register; rfd->0, busy->1; go to START.
- From that edge, txd=0 (start bit).

START:
- txd=0 for exactly CLKS_PER_BIT cycles; then go to DATA with bit index 0.

DATA:
- txd = shift_reg[0] for CLKS_PER_BIT cycles; then shift right and increment the bit index.
- After DATA_BITS bits, go to STOP.

STOP:
- txd=1 for CLKS_PER_BIT cycles.
- At the end: busy->0.
  - If dav_=1, go to IDLE with rfd->1.
  - Else go to WAIT_DAV.

WAIT_DAV:
- txd=1, rfd=0; go to IDLE with rfd->1 on the first edge where dav_=1.

Handshake rules:
- The producer may raise dav_ at any point after rfd falls. The block never recaptures until it has seen dav_=1 after the capture.
- A dav_ pulse held low through the whole frame yields exactly one frame.
- byte_in is sampled only at the capture edge; later changes are ignored.
- rfd rises no earlier than the edge ending the stop bit.

Timing:
- Latency from capture edge to the first txd=0 cycle is 0: txd changes on the capture edge itself.
- Frame length = (DATA_BITS+2)*CLKS_PER_BIT cycles.
- Back-to-back: with dav_ already high at stop end and dav_ low on the following edge, the minimum gap is 1 idle cycle (the IDLE edge).

Counters:
- Cycle counter width is ceil(log2(CLKS_PER_BIT)); it wraps to 0 at CLKS_PER_BIT-1.
- Bit index width is ceil(log2(DATA_BITS+1)).
- Outputs are registered; there are no combinational paths from inputs to txd.

Optional Feature:
SERIAL_TX_PARITY_EN
- Defined: after the last data bit, insert one parity cell (state PARITY) before STOP.
  - Even parity: txd = XOR of the captured DATA_BITS.
  - Frame length becomes (DATA_BITS+3)*CLKS_PER_BIT.
- Undefined: no parity cell; frame as above.
- Handshake and reset behaviour are identical in both builds.

Test Plan:
1. Reset: hold reset_=0 for 3 cycles with dav_=0 and byte_in=8'hFF -> txd=1, rfd=1, busy=0 throughout; no capture.
2. Single frame: CLKS_PER_BIT=4, byte_in=8'hA5, one edge with dav_=0 then dav_=1 -> txd cells 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles total); rfd=1 and busy=0 after cycle 40.
3. Held dav_: dav_=0 for 60 cycles, byte_in=8'h3C -> exactly one frame; rfd stays 0 until the edge after dav_ rises; no second start bit.
4. Back-to-back: send 8'h00 then 8'hFF, dav_ low again 1 cycle after rfd rises -> start of frame 2 occurs 1 cycle after frame 1's stop ends; data cells all 0 then all 1.
5. Reset mid-frame: assert reset_=0 during data bit 3 of 8'h55 -> txd=1 and rfd=1 on that edge; the next request transmits a full fresh frame.
6. Parity build: SERIAL_TX_PARITY_EN defined, byte_in=8'h07 -> parity cell txd=1 before stop; 8'h03 -> parity cell 0; frame 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/serial_transmitter.sv
// serial_transmitter
//   Parallel-in, serial-out asynchronous line transmitter. Takes one word
//   from a producer over a dav_/rfd four-phase handshake and emits it on txd
//   as an idle-high frame: start bit (0), DATA_BITS data bits LSB first,
//   optional even-parity cell, stop bit (1). Each cell is CLKS_PER_BIT clocks.
//
//   Build option: SERIAL_TX_PARITY_EN -- when defined, an even-parity cell
//   (XOR of the captured data bits) is inserted between the last data bit
//   and the stop bit.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset_   in   synchronous reset, active low
//   dav_     in   data available from producer, active low
//   byte_in  in   [DATA_BITS-1:0] data, sampled only on the capture edge
//   rfd      out  ready for data (registered)
//   txd      out  serial line, idle high (registered)
//   busy     out  high from capture until the stop bit completes (registered)
module serial_transmitter #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clock,
    input  logic                 reset_,
    input  logic                 dav_,
    input  logic [DATA_BITS-1:0] byte_in,
    output logic                 rfd,
    output logic                 txd,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    // PARITY is only reachable in the parity build.
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_DAV
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 txd_q, txd_d;
    logic                 rfd_q, rfd_d;
    logic                 busy_q, busy_d;
`ifdef SERIAL_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic cell_end;
    logic [CNT_W-1:0] cnt_next;

    assign cell_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign cnt_next = cell_end ? '0 : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        rfd_d   = rfd_q;
        busy_d  = busy_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (!dav_) begin
                    // Start bit goes out on the capture edge itself.
                    shift_d = byte_in;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^byte_in;
`endif
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = 1'b0;
                    rfd_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                cnt_d = cnt_next;
                if (cell_end) begin
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_next;
                if (cell_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        // Register the next bit now so txd stays a flop output.
                        txd_d = shift_q[1];
                    end
                end
            end
            PARITY: begin
                cnt_d = cnt_next;
                if (cell_end) begin
                    txd_d   = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = cnt_next;
                if (cell_end) begin
                    busy_d = 1'b0;
                    // A dav_ still low here belongs to the frame just sent;
                    // wait for it to rise before offering rfd again.
                    if (dav_) begin
                        rfd_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_DAV;
                    end
                end
            end
            WAIT_DAV: begin
                if (dav_) begin
                    rfd_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            rfd_q   <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            rfd_q   <= rfd_d;
            busy_q  <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign txd  = txd_q;
    assign rfd  = rfd_q;
    assign busy = busy_q;

endmodule
